// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants for seg7_scan_capture: segment patterns, special codes, FSM states.
// Segment vectors are {a,b,c,d,e,f,g} with lit = 1.
package seg7_scan_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_6_ALT = 7'b0011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_7_ALT = 7'b1110010;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_9_ALT = 7'b1110011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_INVALID = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

  function automatic logic [1:0] digit_index(input logic [3:0] en);
    digit_index = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (en[i]) digit_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display-bus and frame-result signals of seg7_scan_capture.
// master drives the display bus; slave is the capture block.
interface seg7_scan_capture_if;
  logic [3:0]  an;
  logic        a, b, c, d, e, f, g;
  logic [15:0] bcd_out;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  digit_seen;

  modport master (
    output an, a, b, c, d, e, f, g,
    input  bcd_out, frame_valid, frame_err, digit_seen
  );

  modport slave (
    input  an, a, b, c, d, e, f, g,
    output bcd_out, frame_valid, frame_err, digit_seen
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD nibble decoder.
// SEG7_BLANK_DIGIT_EN: when defined, all-off decodes to CODE_BLANK as a legal digit.
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = CODE_INVALID;
    invalid = 1'b1;
    case (seg)
      SEG_0:                begin nibble = 4'd0; invalid = 1'b0; end
      SEG_1:                begin nibble = 4'd1; invalid = 1'b0; end
      SEG_2:                begin nibble = 4'd2; invalid = 1'b0; end
      SEG_3:                begin nibble = 4'd3; invalid = 1'b0; end
      SEG_4:                begin nibble = 4'd4; invalid = 1'b0; end
      SEG_5:                begin nibble = 4'd5; invalid = 1'b0; end
      SEG_6, SEG_6_ALT:     begin nibble = 4'd6; invalid = 1'b0; end
      SEG_7, SEG_7_ALT:     begin nibble = 4'd7; invalid = 1'b0; end
      SEG_8:                begin nibble = 4'd8; invalid = 1'b0; end
      SEG_9, SEG_9_ALT:     begin nibble = 4'd9; invalid = 1'b0; end
`ifdef SEG7_BLANK_DIGIT_EN
      SEG_BLANK:            begin nibble = CODE_BLANK; invalid = 1'b0; end
`endif
      default:              begin nibble = CODE_INVALID; invalid = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a 4-digit multiplexed 7-segment bus, rebuilds stable BCD digits and
// publishes complete frames. Optional macro: SEG7_BLANK_DIGIT_EN (see decoder).
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_capture_if.slave    bus
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  logic [3:0]  an_norm;
  logic [6:0]  seg_norm;
  sample_t     sample_q, prev_q;
  state_t      state, state_next;
  logic [7:0]  cnt_q, cnt_next;
  logic        addressed, same, capture;
  logic [1:0]  idx;
  logic [3:0]  nibble;
  logic        invalid;
  logic [15:0] shadow_q;
  logic [3:0]  seen_q, seen_base, seen_next;
  logic        err_pend_q, err_base, err_next;
  logic        done_q, done_next;
  logic [15:0] bcd_q;
  logic        valid_q, ferr_q;

  always_comb begin
    an_norm  = AN_ACTIVE_LOW  ? ~bus.an : bus.an;
    seg_norm = SEG_ACTIVE_LOW ? ~{bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g}
                              :  {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      prev_q   <= '0;
    end else begin
      sample_q <= '{an: an_norm, seg: seg_norm};
      prev_q   <= sample_q;
    end
  end

  assign addressed = $onehot(sample_q.an);
  assign same      = (sample_q == prev_q);
  assign idx       = digit_index(sample_q.an);

  seg7_pattern_decode u_decode (
    .seg     (sample_q.seg),
    .nibble  (nibble),
    .invalid (invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    case (state)
      IDLE: begin
        if (addressed) begin
          cnt_next   = 8'd1;
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (!addressed) begin
          state_next = IDLE;
        end else if (same) begin
          cnt_next = cnt_q + 8'd1;
          if (cnt_next == STABLE_LIMIT) state_next = HELD;
        end else begin
          cnt_next = 8'd1;
        end
      end
      HELD: begin
        if (!same) begin
          cnt_next   = 8'd1;
          state_next = addressed ? TRACK : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture fires in the cycle whose sample completes the stable run.
  always_comb begin
    capture = (state == TRACK) && addressed && same && ((cnt_q + 8'd1) == STABLE_LIMIT);
  end

  // A completion cycle clears the frame first, so a capture there starts the next one.
  always_comb begin
    seen_base = done_q ? '0   : seen_q;
    err_base  = done_q ? 1'b0 : err_pend_q;
    seen_next = seen_base;
    err_next  = err_base;
    if (capture) begin
      seen_next = seen_base | (4'b0001 << idx);
      err_next  = err_base | invalid;
    end
    done_next = capture && (seen_next == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      seen_q     <= '0;
      err_pend_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= done_q;
      if (done_q) begin
        bcd_q  <= shadow_q;
        ferr_q <= err_pend_q;
      end
      if (capture) shadow_q[{idx, 2'b00} +: 4] <= nibble;
      seen_q     <= seen_next;
      err_pend_q <= err_next;
      done_q     <= done_next;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.digit_seen  = seen_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: a run-length reference model predicts frames,
// a monitor compares each frame_valid against the queue.
module tb_seg7_scan_capture;

  localparam int S = 4;

  localparam logic [6:0] PATS [13] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b0011111,
                                       7'b1110000, 7'b1110010, 7'b1111111, 7'b1111011,
                                       7'b1110011};
  localparam logic [3:0] VALS [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6,
                                       4'd7, 4'd7, 4'd8, 4'd9, 4'd9};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_capture_if bus ();

  seg7_scan_capture #(
    .STABLE_CYCLES  (S),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        err;
  } frame_t;

  frame_t      exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [10:0] last_word;
  int          run;
  logic [15:0] m_shadow;
  logic [3:0]  m_seen;
  logic        m_err;
  logic [15:0] last_bcd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec table lookup: returns {invalid, nibble}.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 13; i++)
      if (PATS[i] == p) return {1'b0, VALS[i]};
`ifdef SEG7_BLANK_DIGIT_EN
    if (p == 7'b0000000) return {1'b0, 4'hF};
`endif
    return {1'b1, 4'hE};
  endfunction

  task automatic model_reset();
    m_shadow  = '0;
    m_seen    = '0;
    m_err     = 1'b0;
    last_word = '0;
    run       = 0;
  endtask

  task automatic model_capture(input logic [3:0] en, input logic [6:0] seg);
    logic [4:0] dec;
    int d;
    frame_t fr;
    dec = ref_decode(seg);
    d = 0;
    for (int i = 0; i < 4; i++) if (en[i]) d = i;
    m_shadow[d*4 +: 4] = dec[3:0];
    m_seen[d] = 1'b1;
    m_err = m_err | dec[4];
    if (m_seen == 4'hF) begin
      fr.bcd = m_shadow;
      fr.err = m_err;
      exp_q.push_back(fr);
      last_bcd = m_shadow;
      m_seen = '0;
      m_err = 1'b0;
    end
  endtask

  // en is active-high here; the bus is driven active-low.
  task automatic step(input logic [3:0] en, input logic [6:0] seg);
    logic [10:0] word;
    bus.an = ~en;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg;
    word = {en, seg};
    if (word == last_word) run++;
    else run = 1;
    last_word = word;
    if ($onehot(en) && run == S) model_capture(en, seg);
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(en, seg);
    if (n >= S + 2) chk("digit_seen", {28'd0, bus.digit_seen}, {28'd0, m_seen});
  endtask

  task automatic scan4(input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    hold(4'b1000, s3, 8);
    hold(4'b0100, s2, 8);
    hold(4'b0010, s1, 8);
    hold(4'b0001, s0, 8);
  endtask

  always @(negedge clk) begin
    frame_t fr;
    if (rst_n === 1'b1 && bus.frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", {16'd0, bus.bcd_out}, 32'hFFFF_FFFF);
      end else begin
        fr = exp_q.pop_front();
        chk("frame_bcd", {16'd0, bus.bcd_out}, {16'd0, fr.bcd});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, fr.err});
      end
    end
  end

  initial begin
    logic [3:0] en;
    logic [6:0] seg;
    int         n;
    int         wait_cnt;
    model_reset();
    last_bcd = '0;
    rst_n = 1'b0;
    bus.an = 4'hF;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd_out", {16'd0, bus.bcd_out}, 32'd0);
    chk("rst_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_digit_seen", {28'd0, bus.digit_seen}, 32'd0);
    rst_n = 1'b1;
    hold(4'b0000, 7'b0, 3);

    // Digits 3..0 show 1,2,3,4
    scan4(PATS[1], PATS[2], PATS[3], PATS[4]);

    // Digit 0 glitches 7/1 before settling on 7
    hold(4'b1000, PATS[5], 8);
    hold(4'b0100, PATS[6], 8);
    hold(4'b0010, PATS[10], 8);
    for (int i = 0; i < 2; i++) begin
      hold(4'b0001, PATS[8], 2);
      hold(4'b0001, PATS[1], 2);
    end
    chk("seen_during_glitch", {28'd0, bus.digit_seen}, 32'h0000_000E);
    hold(4'b0001, PATS[8], 4);
    hold(4'b0000, 7'b0, 6);

    // Undecodable digit 2, then a clean frame
    scan4(PATS[1], 7'b1010101, PATS[2], PATS[3]);
    scan4(PATS[4], PATS[3], PATS[2], PATS[1]);

    // Ghosting: all enables active for 20 cycles
    hold(4'b0001, PATS[4], 8);
    hold(4'b0010, PATS[5], 8);
    hold(4'b1111, PATS[8], 20);
    chk("seen_after_ghost", {28'd0, bus.digit_seen}, 32'h0000_0003);
    hold(4'b0100, PATS[6], 8);
    hold(4'b1000, PATS[8], 8);

    // Reset mid-frame
    hold(4'b0001, PATS[1], 8);
    hold(4'b0010, PATS[2], 8);
    bus.an = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("seen_after_reset", {28'd0, bus.digit_seen}, 32'd0);
    chk("valid_after_reset", {31'd0, bus.frame_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    scan4(PATS[11], PATS[10], PATS[8], PATS[6]);

    // All-off digit 3
    scan4(7'b0000000, PATS[5], PATS[12], PATS[0]);

    // Randomized scanning
    for (int k = 0; k < 150; k++) begin
      n = $urandom_range(0, 9);
      if (n < 8) en = 4'b0001 << $urandom_range(0, 3);
      else if (n == 8) en = 4'b0000;
      else en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) seg = PATS[$urandom_range(0, 12)];
      else seg = 7'($urandom_range(0, 127));
      hold(en, seg, $urandom_range(1, 9));
    end
    hold(4'b0000, 7'b0, 4);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("pending_frames", exp_q.size(), 32'd0);
    chk("bcd_out_hold", {16'd0, bus.bcd_out}, {16'd0, last_bcd});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
